// File: rtl/alu_pkg.sv
// alu_pkg: shared operand width, default FIFO depth and operand pair type for the ALU issue stages.
package alu_pkg;
   localparam int OPERAND_W  = 8;
   localparam int FIFO_DEPTH = 4;
   typedef struct packed {
      logic [OPERAND_W-1:0] a;
      logic [OPERAND_W-1:0] b;
   } operand_pair_t;
endpackage

// File: rtl/andn_fifo_mem.sv
// andn_fifo_mem: DEPTH x 2*WIDTH register array, synchronous write, asynchronous read.
module andn_fifo_mem
   import alu_pkg::*;
#(
   parameter int WIDTH = OPERAND_W,
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [2*WIDTH-1:0]       wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [2*WIDTH-1:0]       rdata
);
   logic [2*WIDTH-1:0] mem_q [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end
   assign rdata = mem_q[raddr];
endmodule

// File: rtl/andn_operand_fifo.sv
// andn_operand_fifo: FWFT operand-pair FIFO feeding the andN unit.
// Optional stall counter port enabled by ANDN_FIFO_STALL_STATS_EN.
module andn_operand_fifo
   import alu_pkg::*;
#(
   parameter int WIDTH = OPERAND_W,
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [WIDTH-1:0]         in_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         ina,
   output logic [WIDTH-1:0]         inb,
`ifdef ANDN_FIFO_STALL_STATS_EN
   output logic [15:0]              stall_cnt,
`endif
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic [2*WIDTH-1:0] rdata;
   logic               push, pop;
   assign in_ready  = count_q != CW'(DEPTH);
   assign out_valid = count_q != '0;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign count     = count_q;
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = (push && !pop) ? count_q + CW'(1) : (pop && !push) ? count_q - CW'(1) : count_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
   // Storage is not reset, so the head is masked to zero whenever empty.
   andn_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (push && !rst),
      .waddr (wr_ptr_q),
      .wdata ({in_a, in_b}),
      .raddr (rd_ptr_q),
      .rdata (rdata)
   );
   assign ina = out_valid ? rdata[2*WIDTH-1:WIDTH] : '0;
   assign inb = out_valid ? rdata[WIDTH-1:0] : '0;
`ifdef ANDN_FIFO_STALL_STATS_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   always_comb begin
      stall_cnt_d = (in_valid && !in_ready && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
   end
   always_ff @(posedge clk) begin
      if (rst) stall_cnt_q <= '0;
      else stall_cnt_q <= stall_cnt_d;
   end
   assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_andn_operand_fifo.sv
// tb_andn_operand_fifo: directed checks of the andN operand FIFO.
module tb_andn_operand_fifo;
   logic       clk = 1'b0;
   logic       rst, in_valid, out_ready, in_ready, out_valid;
   logic [7:0] in_a, in_b, ina, inb;
   logic [2:0] count;
`ifdef ANDN_FIFO_STALL_STATS_EN
   logic [15:0] stall_cnt;
`endif
   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] drain_exp [4];
   always #5 clk = ~clk;
   andn_operand_fifo dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ina       (ina),
      .inb       (inb),
`ifdef ANDN_FIFO_STALL_STATS_EN
      .stall_cnt (stall_cnt),
`endif
      .count     (count)
   );
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic push(input logic [7:0] a, input logic [7:0] b);
      in_valid = 1'b1; in_a = a; in_b = b;
      step();
      in_valid = 1'b0;
   endtask
   initial begin
      drain_exp[0] = 8'hB6; drain_exp[1] = 8'hA0; drain_exp[2] = 8'h82; drain_exp[3] = 8'h80;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
      step(); step();
      rst = 1'b0;
      step();
      chk("rst_count", 32'(count), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_ina", 32'(ina), 0);
      chk("rst_inb", 32'(inb), 0);
      push(8'hB6, 8'hFF);
      chk("p1_out_valid", 32'(out_valid), 1);
      chk("p1_ina", 32'(ina), 32'hB6);
      chk("p1_inb", 32'(inb), 32'hFF);
      chk("p1_count", 32'(count), 1);
      chk("p1_and", 32'(ina & inb), 32'hB6);
      push(8'hB6, 8'hE0);
      push(8'hB6, 8'h83);
      push(8'hB6, 8'h80);
      chk("full_count", 32'(count), 4);
      chk("full_in_ready", 32'(in_ready), 0);
      push(8'h11, 8'h22);
      chk("held_count", 32'(count), 4);
      chk("held_in_ready", 32'(in_ready), 0);
`ifdef ANDN_FIFO_STALL_STATS_EN
      chk("stall_cnt", 32'(stall_cnt), 1);
`endif
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_valid", 32'(out_valid), 1);
         chk("drain_and", 32'(ina & inb), 32'(drain_exp[i]));
         step();
      end
      out_ready = 1'b0;
      chk("drained_valid", 32'(out_valid), 0);
      chk("drained_count", 32'(count), 0);
      chk("drained_ina", 32'(ina), 0);
      push(8'h01, 8'hF1);
      push(8'h02, 8'hF2);
      for (int k = 0; k < 6; k++) begin
         in_valid = 1'b1; out_ready = 1'b1;
         in_a = 8'(k + 3); in_b = 8'hF0 | 8'(k + 3);
         chk("pp_ina", 32'(ina), 32'(k + 1));
         chk("pp_inb", 32'(inb), 32'(8'hF0 | 8'(k + 1)));
         step();
         chk("pp_count", 32'(count), 2);
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("pp_head", 32'(ina), 32'h07);
      push(8'h09, 8'hF9);
      chk("pre_rst_count", 32'(count), 3);
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_a = 8'hAA; in_b = 8'hBB;
      step();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_ina", 32'(ina), 0);
      push(8'h55, 8'h66);
      chk("post_rst_ina", 32'(ina), 32'h55);
      chk("post_rst_inb", 32'(inb), 32'h66);
      chk("post_rst_count", 32'(count), 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
